adjust_ctrl: RTL and testbench

Time-setting controller for the millennium clock. It turns raw mode/up/down buttons into the control signals that drive the time-field counters (seconds, minutes, hours, day, month, year). It selects which field is being adjusted and issues single-cycle up/down strobes, with auto-repeat while a button is held. It gates the 1 Hz count enable off while setting, and returns to run mode after an inactivity timeout. It sits between the button inputs and the counter chain, and all counters run on its single system clock.

---
 rtl/adjust_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_adjust_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_ctrl.sv
// Purpose: time-setting controller; turns mode/up/down buttons into field select, up/down strobes, and a gated 1 Hz enable.
// Latency: 3 cycles from a button rising to its strobe or state change; all outputs are registered.
// Backpressure: none; strobes are single-cycle fire-and-forget pulses, and the 1 Hz enable is dropped while setting.
// Ports: clk, rst_n (synchronous, active-low); tick_1hz 1 Hz pulse; btn_mode/btn_up/btn_down debounced async levels;
//        adjust (any set state), field_sel (one-hot sec..year), up_pulse/down_pulse, en_1 (tick gated to RUN), blink.
module adjust_ctrl #(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       adjust,
  output logic [5:0] field_sel,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       en_1,
  output logic       blink
);

  localparam int RPT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int TW      = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_S);

  // One-hot state encoding doubles as field_sel, so the select comes straight off flops.
  typedef enum logic [5:0] {
    RUN      = 6'b000000,
    SET_SEC  = 6'b000001,
    SET_MIN  = 6'b000010,
    SET_HOUR = 6'b000100,
    SET_DAY  = 6'b001000,
    SET_MON  = 6'b010000,
    SET_YEAR = 6'b100000
  } state_t;

  state_t state;

  // Button conditioning, bit order {down, up, mode}.
  logic [2:0] sync1, sync2, hist, armed, edge_q;
  logic [1:0] vld;

  // Auto-repeat and inactivity bookkeeping.
  logic [HW-1:0] hold_cnt;
  logic          hold_act;
  logic          hold_dir;   // 1: up is the held button, 0: down
  logic          rep_phase;  // 0: waiting HOLD_CYC, 1: waiting REPEAT_CYC
  logic [TW-1:0] inact;

  function automatic state_t next_field(input state_t s);
    case (s)
      RUN:      next_field = SET_SEC;
      SET_SEC:  next_field = SET_MIN;
      SET_MIN:  next_field = SET_HOUR;
      SET_HOUR: next_field = SET_DAY;
      SET_DAY:  next_field = SET_MON;
      SET_MON:  next_field = SET_YEAR;
      default:  next_field = RUN;
    endcase
  endfunction

  // A button only counts as pressed after it has been seen released since reset:
  // vld marks when sync2 carries real samples, armed remembers a seen-low level.
  // edge_q registers the press so the strobe lands 3 cycles after the input rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      hist   <= '0;
      armed  <= '0;
      edge_q <= '0;
      vld    <= '0;
    end else begin
      sync1  <= {btn_down, btn_up, btn_mode};
      sync2  <= sync1;
      hist   <= sync2;
      vld    <= {vld[0], 1'b1};
      armed  <= armed | (~sync2 & {3{vld[1]}});
      edge_q <= sync2 & ~hist & armed;
    end
  end

  logic mode_e, up_e, dn_e, up_l, dn_l, both, held, at_limit, rep_fire;

  assign mode_e   = edge_q[0];
  assign up_e     = edge_q[1];
  assign dn_e     = edge_q[2];
  assign up_l     = sync2[1];
  assign dn_l     = sync2[2];
  // Both buttons active at once cancels everything, including coincident presses.
  assign both     = (up_l & dn_l) | (up_e & dn_e);
  assign held     = hold_dir ? up_l : dn_l;
  assign at_limit = rep_phase ? (hold_cnt == REP_LAST) : (hold_cnt == HOLD_LAST);
  assign rep_fire = hold_act & held & at_limit & ~both & ~up_e & ~dn_e;

  assign field_sel = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      adjust     <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      en_1       <= 1'b0;
      blink      <= 1'b0;
      hold_cnt   <= '0;
      hold_act   <= 1'b0;
      hold_dir   <= 1'b0;
      rep_phase  <= 1'b0;
      inact      <= '0;
    end else begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      // Qualified by the state during the tick cycle, so a tick as we leave RUN still counts.
      en_1       <= tick_1hz & (state == RUN);

      if (mode_e) begin
        // Mode has priority: any coincident strobe is dropped.
        state     <= next_field(state);
        adjust    <= (next_field(state) != RUN);
        hold_cnt  <= '0;
        hold_act  <= 1'b0;
        rep_phase <= 1'b0;
        inact     <= '0;
        blink     <= 1'b0;
      end else if (state != RUN) begin
        if (both) begin
          hold_cnt  <= '0;
          hold_act  <= 1'b0;
          rep_phase <= 1'b0;
        end else if (up_e | dn_e) begin
          up_pulse   <= up_e;
          down_pulse <= dn_e;
          hold_cnt   <= '0;
          hold_act   <= 1'b1;
          hold_dir   <= up_e;
          rep_phase  <= 1'b0;
        end else if (!hold_act || !held) begin
          hold_cnt  <= '0;
          hold_act  <= 1'b0;
          rep_phase <= 1'b0;
        end else if (at_limit) begin
          up_pulse   <= hold_dir;
          down_pulse <= ~hold_dir;
          hold_cnt   <= '0;
          rep_phase  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end

        if (up_e | dn_e | rep_fire) begin
          inact <= '0;
          if (tick_1hz) blink <= ~blink;
        end else if (inact == TMO_LAST) begin
          state     <= RUN;
          adjust    <= 1'b0;
          inact     <= '0;
          blink     <= 1'b0;
          hold_cnt  <= '0;
          hold_act  <= 1'b0;
          rep_phase <= 1'b0;
        end else if (tick_1hz) begin
          inact <= inact + 1'b1;
          blink <= ~blink;
        end
      end else begin
        hold_cnt  <= '0;
        hold_act  <= 1'b0;
        rep_phase <= 1'b0;
        inact     <= '0;
        blink     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adjust_ctrl.sv
// Bench for adjust_ctrl: directed scenarios plus randomized button/tick traffic,
// every cycle compared against a field-index / timestamp reference model.
`timescale 1ns/1ps
module tb_adjust_ctrl;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int TMO  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       adjust;
  logic [5:0] field_sel;
  logic       up_pulse;
  logic       down_pulse;
  logic       en_1;
  logic       blink;

  adjust_ctrl #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP), .TIMEOUT_S(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .adjust(adjust), .field_sel(field_sel), .up_pulse(up_pulse),
    .down_pulse(down_pulse), .en_1(en_1), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: field index 0 = RUN, 1..6 = sec..year.
  int m_idx = 0, m_n = 0, m_t0 = 0, m_ticks = 0;
  bit m_act = 0, m_dir = 0, m_blink = 0, m_up = 0, m_dn = 0, m_en = 0;
  bit [4:0] h_m = '0, h_u = '0, h_d = '0;  // h[k] = input sampled k edges ago

  task automatic model_step();
    bit pm, pu, pd, lu, ld, both, fired, timed;
    int dt;
    if (!rst_n) begin
      m_idx = 0; m_n = 0; m_act = 0; m_ticks = 0; m_blink = 0;
      m_up = 0; m_dn = 0; m_en = 0; h_m = '0; h_u = '0; h_d = '0;
      return;
    end
    m_n++;
    h_m = {h_m[3:0], btn_mode};
    h_u = {h_u[3:0], btn_up};
    h_d = {h_d[3:0], btn_down};
    // A press takes effect 3 edges after the input rises, and only for
    // a low-to-high change sampled after reset.
    pm = (m_n >= 5) && h_m[3] && !h_m[4];
    pu = (m_n >= 5) && h_u[3] && !h_u[4];
    pd = (m_n >= 5) && h_d[3] && !h_d[4];
    lu = h_u[2];
    ld = h_d[2];
    m_en = tick_1hz && (m_idx == 0);
    m_up = 0; m_dn = 0; fired = 0; timed = 0;
    if (pm) begin
      m_idx = (m_idx + 1) % 7;
      m_act = 0; m_ticks = 0; m_blink = 0;
    end else if (m_idx != 0) begin
      both = (lu && ld) || (pu && pd);
      if (both) m_act = 0;
      else if (pu || pd) begin
        m_up = pu; m_dn = pd; m_act = 1; m_dir = pu; m_t0 = m_n;
      end else if (m_act && (m_dir ? lu : ld)) begin
        dt = m_n - m_t0;
        if (dt == HOLD || (dt > HOLD && (dt - HOLD) % REP == 0)) begin
          m_up = m_dir; m_dn = !m_dir; fired = 1;
        end
      end else m_act = 0;
      if (pu || pd || fired) m_ticks = 0;
      else if (m_ticks == TMO) begin
        timed = 1; m_idx = 0; m_ticks = 0; m_act = 0;
      end else if (tick_1hz) m_ticks++;
      if (timed) m_blink = 0;
      else if (tick_1hz) m_blink = !m_blink;
    end else begin
      m_act = 0; m_ticks = 0; m_blink = 0;
    end
  endtask

  int tick_mode = 0, tick_cnt = 0;
  int n_up = 0, n_dn = 0, n_en = 0;

  task automatic cycle();
    int exp_fs;
    @(posedge clk);
    model_step();
    #1;
    exp_fs = (m_idx == 0) ? 0 : (1 << (m_idx - 1));
    chk("up_pulse", up_pulse, m_up);
    chk("down_pulse", down_pulse, m_dn);
    chk("en_1", en_1, m_en);
    chk("blink", blink, m_blink);
    chk("field_sel", field_sel, exp_fs);
    chk("adjust", adjust, m_idx != 0);
    if (up_pulse) n_up++;
    if (down_pulse) n_dn++;
    if (en_1) n_en++;
    @(negedge clk);
    case (tick_mode)
      0: tick_1hz = 1'b0;
      1: begin tick_1hz = (tick_cnt % 10 == 0); tick_cnt++; end
      default: tick_1hz = ($urandom_range(0, 5) == 0);
    endcase
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; run(3);
    btn_mode = 1'b0; run(5);
  endtask

  logic [5:0] exp_fs_tab [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                                 6'b010000, 6'b100000, 6'b000000};

  initial begin
    int r;
    // Reset with every button held high.
    btn_mode = 1'b1; btn_up = 1'b1; btn_down = 1'b1; rst_n = 1'b0;
    run(3);
    chk("rst_field_sel", field_sel, 0);
    chk("rst_adjust", adjust, 0);
    rst_n = 1'b1;
    run(12);
    chk("rst_held_field_sel", field_sel, 0);
    chk("rst_held_up_count", n_up, 0);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    run(6);

    // Mode stepping through every field and back to RUN.
    for (int i = 0; i < 7; i++) begin
      press_mode();
      chk("mode_field_sel", field_sel, exp_fs_tab[i]);
      chk("mode_adjust", adjust, (i < 6) ? 1 : 0);
    end

    // SET_MIN, hold up for 30 cycles.
    press_mode(); press_mode();
    chk("min_field_sel", field_sel, 2);
    n_up = 0; n_dn = 0;
    btn_up = 1'b1; run(30);
    btn_up = 1'b0; run(12);
    chk("hold_up_count", n_up, 7);
    chk("hold_down_count", n_dn, 0);

    // SET_SEC, up and down together.
    for (int i = 0; i < 6; i++) press_mode();
    chk("sec_field_sel", field_sel, 1);
    n_up = 0; n_dn = 0;
    btn_up = 1'b1; btn_down = 1'b1; run(15);
    btn_up = 1'b0; btn_down = 1'b0; run(6);
    chk("both_up_count", n_up, 0);
    chk("both_down_count", n_dn, 0);

    // Back to RUN, up is ignored.
    for (int i = 0; i < 6; i++) press_mode();
    n_up = 0;
    btn_up = 1'b1; run(8);
    btn_up = 1'b0; run(5);
    chk("run_up_count", n_up, 0);
    chk("run_field_sel", field_sel, 0);

    // Ticks every 10 cycles: en_1 in RUN, then inactivity timeout from SET_SEC.
    tick_mode = 1; tick_cnt = 0; n_en = 0;
    run(31);
    chk("run_en_count", n_en, 3);
    press_mode();
    run(60);
    chk("timeout_field_sel", field_sel, 0);
    chk("timeout_blink", blink, 0);
    tick_mode = 0;
    run(2);

    // Mode and up together from SET_HOUR.
    press_mode(); press_mode(); press_mode();
    chk("hour_field_sel", field_sel, 4);
    n_up = 0;
    btn_mode = 1'b1; btn_up = 1'b1; run(3);
    btn_mode = 1'b0; btn_up = 1'b0; run(5);
    chk("mode_up_field_sel", field_sel, 8);
    chk("mode_up_count", n_up, 0);

    // Reset during auto-repeat in SET_DAY.
    btn_up = 1'b1; run(14);
    n_up = 0;
    rst_n = 1'b0; run(3);
    rst_n = 1'b1; run(10);
    chk("rst_repeat_up_count", n_up, 0);
    btn_up = 1'b0; run(6);
    chk("rst_repeat_field_sel", field_sel, 0);

    // Randomized traffic.
    tick_mode = 2;
    for (int s = 0; s < 350; s++) begin
      r = $urandom_range(0, 19);
      btn_mode = (r < 4);
      btn_up   = (r >= 3 && r < 10);
      btn_down = (r >= 8 && r < 13);
      rst_n    = (r != 19);
      run((r == 19) ? 2 : $urandom_range(1, 24));
    end
    rst_n = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
